// File: rtl/net_router_input_queue_sep.sv
// Router input stage: steers each incoming message by its security-domain tag
// into one of two fully independent circular FIFOs, each with a val/rdy head.
module net_router_input_queue_sep #(
  parameter  int unsigned p_num_routers = 8,
  parameter  int unsigned p_msg_nbits   = 44,
  parameter  int unsigned p_num_entries = 4,
  localparam int unsigned c_dest_nbits  = $clog2(p_num_routers),
  localparam int unsigned c_cnt_nbits   = $clog2(p_num_entries) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [p_msg_nbits-1:0]  in_msg,
  input  logic                    in_domain,
  output logic                    out_val_d1,
  input  logic                    out_rdy_d1,
  output logic [p_msg_nbits-1:0]  out_msg_d1,
  output logic [c_dest_nbits-1:0] out_dest_d1,
  output logic                    out_val_d2,
  input  logic                    out_rdy_d2,
  output logic [p_msg_nbits-1:0]  out_msg_d2,
  output logic [c_dest_nbits-1:0] out_dest_d2,
  output logic [c_cnt_nbits-1:0]  count_d1,
  output logic [c_cnt_nbits-1:0]  count_d2
);

  localparam int unsigned             c_ptr_nbits = $clog2(p_num_entries);
  localparam logic [c_cnt_nbits-1:0]  c_full      = c_cnt_nbits'(p_num_entries);

  logic [1:0]             q_rdy;
  logic [1:0]             q_val;
  logic [p_msg_nbits-1:0] q_msg [2];
  logic [c_cnt_nbits-1:0] q_cnt [2];

  assign q_rdy = {out_rdy_d2, out_rdy_d1};

  // Readiness looks only at the selected queue's count, never at a same-cycle
  // dequeue, so a full queue refuses input even while draining.
  assign in_rdy = in_domain ? (q_cnt[1] != c_full) : (q_cnt[0] != c_full);

  for (genvar d = 0; d < 2; d++) begin : g_dom
    logic [p_msg_nbits-1:0] mem [p_num_entries];
    logic [c_ptr_nbits-1:0] head;
    logic [c_ptr_nbits-1:0] tail;
    logic [c_cnt_nbits-1:0] cnt;
    logic                   enq;
    logic                   deq;

    assign enq = in_val && in_rdy && (in_domain == 1'(d));
    assign deq = (cnt != '0) && q_rdy[d];

    // Depth is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (enq) tail <= tail + 1'b1;
        if (deq) head <= head + 1'b1;
        case ({enq, deq})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (enq) mem[tail] <= in_msg;
    end

    assign q_cnt[d] = cnt;
    assign q_val[d] = (cnt != '0);
    assign q_msg[d] = q_val[d] ? mem[head] : '0;
  end

  assign out_val_d1  = q_val[0];
  assign out_msg_d1  = q_msg[0];
  assign out_dest_d1 = out_msg_d1[p_msg_nbits-1 -: c_dest_nbits];
  assign count_d1    = q_cnt[0];

  assign out_val_d2  = q_val[1];
  assign out_msg_d2  = q_msg[1];
  assign out_dest_d2 = out_msg_d2[p_msg_nbits-1 -: c_dest_nbits];
  assign count_d2    = q_cnt[1];

endmodule

// File: tb/tb_net_router_input_queue_sep.sv
// Scoreboard bench for net_router_input_queue_sep: directed stimulus pushes
// expected messages per domain; a negedge monitor pops them as heads are consumed.
module tb_net_router_input_queue_sep;

  localparam int unsigned NR = 8;
  localparam int unsigned MW = 44;
  localparam int unsigned NE = 4;
  localparam int unsigned DW = 3;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [MW-1:0] in_msg;
  logic          in_domain;
  logic          out_val_d1, out_rdy_d1, out_val_d2, out_rdy_d2;
  logic [MW-1:0] out_msg_d1, out_msg_d2;
  logic [DW-1:0] out_dest_d1, out_dest_d2;
  logic [CW-1:0] count_d1, count_d2;

  net_router_input_queue_sep #(
    .p_num_routers (NR),
    .p_msg_nbits   (MW),
    .p_num_entries (NE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_msg      (in_msg),
    .in_domain   (in_domain),
    .out_val_d1  (out_val_d1),
    .out_rdy_d1  (out_rdy_d1),
    .out_msg_d1  (out_msg_d1),
    .out_dest_d1 (out_dest_d1),
    .out_val_d2  (out_val_d2),
    .out_rdy_d2  (out_rdy_d2),
    .out_msg_d2  (out_msg_d2),
    .out_dest_d2 (out_dest_d2),
    .count_d1    (count_d1),
    .count_d2    (count_d2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [MW-1:0] sb1[$];
  logic [MW-1:0] sb2[$];
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] mk(input int unsigned d, input int unsigned p);
    logic [DW-1:0] dd;
    logic [MW-DW-1:0] pp;
    dd = d[DW-1:0];
    pp = (MW-DW)'(p);
    return {dd, pp};
  endfunction

  // Monitor: a head consumed this cycle must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (out_val_d1 && out_rdy_d1) begin
        if (sb1.size() == 0) begin
          total++; bad++;
          $display("FAIL d1_spurious: got 0x%0h expected no output", out_msg_d1);
        end else begin
          logic [MW-1:0] e;
          e = sb1.pop_front();
          chk("d1_msg", 64'(out_msg_d1), 64'(e));
          chk("d1_dest", 64'(out_dest_d1), 64'(e[MW-1 -: DW]));
        end
      end
      if (out_val_d2 && out_rdy_d2) begin
        if (sb2.size() == 0) begin
          total++; bad++;
          $display("FAIL d2_spurious: got 0x%0h expected no output", out_msg_d2);
        end else begin
          logic [MW-1:0] e;
          e = sb2.pop_front();
          chk("d2_msg", 64'(out_msg_d2), 64'(e));
          chk("d2_dest", 64'(out_dest_d2), 64'(e[MW-1 -: DW]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one message for one edge; exp_rdy is the hand-derived acceptance.
  task automatic send(input logic dom, input logic [MW-1:0] m, input logic exp_rdy);
    in_val = 1'b1; in_domain = dom; in_msg = m;
    #1;
    chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    if (exp_rdy) begin
      if (dom) sb2.push_back(m);
      else     sb1.push_back(m);
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned sent;
    int unsigned cyc;
    reset = 1'b0; in_val = 1'b0; in_msg = '0; in_domain = 1'b0;
    out_rdy_d1 = 1'b0; out_rdy_d2 = 1'b0;

    // Reset then idle
    tick(); tick();
    chk("rst_val_d1", 64'(out_val_d1), 0);
    chk("rst_val_d2", 64'(out_val_d2), 0);
    chk("rst_cnt_d1", 64'(count_d1), 0);
    chk("rst_cnt_d2", 64'(count_d2), 0);
    chk("rst_msg_d1", 64'(out_msg_d1), 0);
    chk("rst_msg_d2", 64'(out_msg_d2), 0);
    reset = 1'b1;
    mon_en = 1'b1;
    in_domain = 1'b0; #1 chk("idle_rdy_d1", 64'(in_rdy), 1);
    in_domain = 1'b1; #1 chk("idle_rdy_d2", 64'(in_rdy), 1);
    tick();

    // Steering with one-cycle latency
    in_val = 1'b1; in_domain = 1'b0; in_msg = mk(5, 'h11);
    #1 chk("no_bypass_d1", 64'(out_val_d1), 0);
    in_val = 1'b0;
    send(1'b0, mk(5, 'h11), 1'b1);
    chk("steer_cnt_d1", 64'(count_d1), 1);
    chk("steer_dest_d1", 64'(out_dest_d1), 5);
    chk("steer_cnt_d2_idle", 64'(count_d2), 0);
    send(1'b1, mk(3, 'h22), 1'b1);
    chk("steer_cnt_d2", 64'(count_d2), 1);
    chk("steer_dest_d2", 64'(out_dest_d2), 3);
    chk("steer_cnt_d1_hold", 64'(count_d1), 1);
    out_rdy_d1 = 1'b1; out_rdy_d2 = 1'b1;
    tick();
    out_rdy_d1 = 1'b0; out_rdy_d2 = 1'b0;
    chk("drain_cnt_d1", 64'(count_d1), 0);
    chk("drain_cnt_d2", 64'(count_d2), 0);
    chk("empty_msg_d1", 64'(out_msg_d1), 0);
    chk("empty_dest_d2", 64'(out_dest_d2), 0);

    // Fill domain 1, check isolation from domain 2
    for (int i = 1; i <= 4; i++) send(1'b0, mk(i, 'h100 + i), 1'b1);
    chk("full_cnt_d1", 64'(count_d1), 4);
    in_domain = 1'b0; #1 chk("full_rdy_d1", 64'(in_rdy), 0);
    in_domain = 1'b1; #1 chk("iso_rdy_d2", 64'(in_rdy), 1);
    send(1'b1, mk(7, 'h200), 1'b1);
    chk("iso_cnt_d2", 64'(count_d2), 1);
    chk("iso_cnt_d1", 64'(count_d1), 4);

    // Full with simultaneous dequeue: still refuses input
    out_rdy_d1 = 1'b1;
    send(1'b0, mk(0, 'h3ff), 1'b0);
    out_rdy_d1 = 1'b0;
    chk("fulldq_cnt_d1", 64'(count_d1), 3);
    chk("fulldq_head_d1", 64'(out_msg_d1), 64'(mk(2, 'h102)));
    out_rdy_d1 = 1'b1; out_rdy_d2 = 1'b1;
    repeat (4) tick();
    out_rdy_d1 = 1'b0; out_rdy_d2 = 1'b0;
    chk("fulldq_drain_d1", 64'(count_d1), 0);
    chk("fulldq_drain_d2", 64'(count_d2), 0);

    // Wrap-around ordering on domain 2 with toggling downstream
    sent = 0; cyc = 0;
    while (sent < 10 && cyc < 200) begin
      in_val = 1'b1; in_domain = 1'b1; in_msg = mk(sent % 8, sent);
      out_rdy_d2 = cyc[0];
      #1;
      if (in_rdy) begin
        sb2.push_back(in_msg);
        sent++;
      end
      @(posedge clk); #1;
      chk("wrap_cnt_le4", 64'(count_d2 <= 3'd4), 1);
      cyc++;
    end
    in_val = 1'b0;
    chk("wrap_sent", 64'(sent), 10);
    out_rdy_d2 = 1'b1;
    cyc = 0;
    while (count_d2 != 0 && cyc < 50) begin tick(); cyc++; end
    out_rdy_d2 = 1'b0;
    chk("wrap_drained", 64'(count_d2), 0);
    chk("wrap_sb_empty", 64'(sb2.size()), 0);

    // Reset mid-operation
    send(1'b0, mk(1, 'h51), 1'b1);
    send(1'b0, mk(2, 'h52), 1'b1);
    send(1'b1, mk(3, 'h61), 1'b1);
    send(1'b1, mk(4, 'h62), 1'b1);
    chk("pre_rst_cnt_d1", 64'(count_d1), 2);
    chk("pre_rst_cnt_d2", 64'(count_d2), 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_val_d1", 64'(out_val_d1), 0);
    chk("arst_val_d2", 64'(out_val_d2), 0);
    chk("arst_cnt_d1", 64'(count_d1), 0);
    chk("arst_cnt_d2", 64'(count_d2), 0);
    chk("arst_msg_d1", 64'(out_msg_d1), 0);
    chk("arst_msg_d2", 64'(out_msg_d2), 0);
    sb1.delete(); sb2.delete();
    reset = 1'b1;
    tick();
    chk("post_rst_val_d1", 64'(out_val_d1), 0);
    chk("post_rst_val_d2", 64'(out_val_d2), 0);
    send(1'b0, mk(6, 'h77), 1'b1);
    chk("post_rst_cnt_d1", 64'(count_d1), 1);
    chk("post_rst_head_d1", 64'(out_msg_d1), 64'(mk(6, 'h77)));
    chk("post_rst_val_d2b", 64'(out_val_d2), 0);
    out_rdy_d1 = 1'b1;
    tick();
    out_rdy_d1 = 1'b0;
    chk("final_cnt_d1", 64'(count_d1), 0);
    chk("final_sb_empty", 64'(sb1.size() + sb2.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/net_router_input_queue_sep.md
Name: net_router_input_queue_sep

Overview:
Per-port router input stage for the domain-separated network. It accepts one message per cycle from the link and steers it by its security-domain tag into one of two independent circular FIFOs, domain 1 or domain 2. Each FIFO presents a val/rdy head and the extracted destination field to the downstream per-domain input-control/arbitration stage. The two queues share no state, so backpressure and occupancy in one domain never affect the other.

Parameters:
p_num_routers, 8, number of routers; sets c_dest_nbits = $clog2(p_num_routers)
p_msg_nbits, 44, full message width; destination field is msg[p_msg_nbits-1 -: c_dest_nbits]
p_num_entries, 4, depth of each domain FIFO; power of two, >= 2
c_dest_nbits, derived, not set externally
c_cnt_nbits, derived, $clog2(p_num_entries)+1, not set externally

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset: 0 = reset asserted
in_val  input  1  incoming message valid
in_rdy  output  1  target queue can accept
in_msg  input  p_msg_nbits  incoming message
in_domain  input  1  0 = domain 1, 1 = domain 2; qualified by in_val
out_val_d1  output  1  domain-1 head valid
out_rdy_d1  input  1  downstream consumes domain-1 head
out_msg_d1  output  p_msg_nbits  domain-1 head message
out_dest_d1  output  c_dest_nbits  domain-1 head destination
out_val_d2  output  1  domain-2 head valid
out_rdy_d2  input  1  downstream consumes domain-2 head
out_msg_d2  output  p_msg_nbits  domain-2 head message
out_dest_d2  output  c_dest_nbits  domain-2 head destination
count_d1  output  c_cnt_nbits  domain-1 occupancy
count_d2  output  c_cnt_nbits  domain-2 occupancy

Behaviour:
- Reset asserted (reset==0, asynchronous): head/tail pointers and counts of both queues go to 0 immediately. out_val_d1/d2 = 0, count_d1/d2 = 0, out_msg/out_dest = 0. Storage array is not reset.
- Reset mid-operation: all queued messages are discarded. On the first edge after deassertion, both queues are empty.
- in_rdy is combinational: when in_domain==0, in_rdy = (count_d1 != p_num_entries); when in_domain==1, in_rdy = (count_d2 != p_num_entries). in_rdy depends only on the selected queue.
- Enqueue fires when in_val && in_rdy. The message is written at the tail of the selected queue and the tail advances modulo p_num_entries. Pointer wrap goes from p_num_entries-1 to 0.
- Dequeue on domain X fires when out_val_dX && out_rdy_dX. The head advances modulo p_num_entries.
- out_val_dX = (count_dX != 0). out_msg_dX = storage[head] when valid, otherwise forced to all-zeros. out_dest_dX is sliced from out_msg_dX, so it is also 0 when empty. There is no stale-data leakage.
- No bypass: a message enqueued in cycle N appears at the head no earlier than cycle N+1. Minimum latency is 1 cycle.
- Full queue: in_rdy=0 for that domain even if a dequeue is firing the same cycle. There is no pipe-through.
- Empty queue: out_val=0 and out_rdy is ignored. Count never underflows.
- Simultaneous enqueue and dequeue on the same non-full, non-empty queue: count is unchanged and both pointers advance.
- Simultaneous dequeues on d1 and d2 in one cycle are independent and both legal.
- Count update per queue: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- in_domain and in_msg are don't-care when in_val=0. There is no state change.
- Sustained throughput is 1 message/cycle per domain when downstream is always ready.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> out_val_d1=out_val_d2=0, count_d1=count_d2=0, out_msg_d1=out_msg_d2=0, in_rdy=1 for either domain.
- Steering: send msg with dest=5 on domain 0, then dest=3 on domain 1, downstream not ready -> count_d1=1 with out_dest_d1=5; count_d2=1 with out_dest_d2=3; one cycle latency each.
- Full/isolation (p_num_entries=4): enqueue 4 messages to domain 1 with out_rdy_d1=0 -> count_d1=4; in_rdy=0 when in_domain=0 but 1 when in_domain=1. A domain-2 message is accepted and count_d2=1.
- Full with simultaneous dequeue: domain-1 queue full, out_rdy_d1=1, in_val=1, in_domain=0 -> in_rdy=0; after the edge count_d1=3 and the head is the second message.
- Wrap-around ordering: stream 10 messages with payloads 0..9 into domain 2, out_rdy_d2 toggling every cycle -> all 10 dequeued in order 0..9 with no loss or duplication; count_d2 never exceeds 4.
- Reset mid-operation: both queues holding 2 messages, pulse reset=0 between edges -> outputs drop to 0 asynchronously; after release both queues are empty and the next enqueue appears as the sole head entry.
